multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
// - Main control FSM of the multi-cycle MIPS datapath. Decodes opcode_i and sequences
//   IF/ID/EX/MEM/WB, driving the 3-bit ALUOp consumed by ALU_Ctrl plus all datapath
//   enables and mux selects.
// - Instruction/data memory is shared and handshaked (req/ready). Branch resolution
//   uses the ALU zero flag.
// PARAMETERS
// - MEM_TIMEOUT  default 15  memory wait cycles before bus_err_o; 0 = never time out
// PORTS
// - clk_i          in   1  clock; all state changes on the rising edge
// - rst_i          in   1  synchronous, active-high reset
// - opcode_i       in   6  IR[31:26]; sampled only in ID
// - zero_i         in   1  ALU zero flag; sampled in EX of beq/bne
// - mem_ready_i    in   1  memory completes the current request this cycle
// - alu_op_o       out  3  ALUOp to ALU_Ctrl
// - alu_src_a_o    out  1  0 = PC, 1 = rs
// - alu_src_b_o    out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
// - pc_we_o        out  1  PC write enable
// - pc_src_o       out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target
// - ir_we_o        out  1  IR write enable
// - mem_req_o      out  1  memory request; held until mem_ready_i
// - mem_we_o       out  1  1 = write (sw); valid only while mem_req_o = 1
// - iord_o         out  1  address mux: 0 = PC, 1 = ALUOut
// - reg_we_o       out  1  register-file write enable
// - reg_dst_o      out  1  0 = rt, 1 = rd
// - mem_to_reg_o   out  1  0 = ALUOut, 1 = MDR
// - ill_op_o       out  1  one-cycle pulse on an undefined opcode
// - bus_err_o      out  1  one-cycle pulse on a memory timeout
// - state_o        out  4  current state encoding, for debug
// BEHAVIOUR
// - Reset: state = IF; every output is 0, except state_o = IF encoding; wait counter = 0.
//   Reset asserted mid-instruction aborts it; no write enable is asserted that cycle.
// - Outputs are Moore: a function of state and latched opcode. The exceptions are
//   pc_we_o, ir_we_o and the branch decision, which are qualified by mem_ready_i/zero_i.
// - IF: mem_req_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=ADD.
//   - On mem_ready_i: ir_we_o=1, pc_we_o=1, pc_src_o=0, next state ID.
//   - Otherwise stay in IF. No IR/PC write occurs until ready.
// - ID: latch opcode_i; alu_src_b_o=3, alu_op_o=ADD (branch target into ALUOut).
//   - Next state by opcode:
//     - R 000000 -> EX_R
//     - addi 001000 / lui 001111 -> EX_I
//     - lw 100011 / sw 101011 -> EX_ADDR
//     - beq 000100 / bne 000101 -> EX_BR
//     - j 000010 -> EX_J
//     - any other opcode -> ill_op_o=1, next state IF (PC already advanced)
// - EX_R: alu_src_a_o=1, alu_src_b_o=0, alu_op_o=RTYPE -> WB_ALU (reg_dst_o=1).
// - EX_I: alu_src_a_o=1, alu_src_b_o=2, alu_op_o = ADD (addi) or LUI -> WB_ALU (reg_dst_o=0).
// - EX_ADDR: alu_src_a_o=1, alu_src_b_o=2, alu_op_o=ADD -> MEM.
// - MEM: mem_req_o=1, iord_o=1, mem_we_o = (op==sw). Stay until mem_ready_i.
//   - On ready: lw -> WB_MEM; sw -> IF.
// - WB_MEM: reg_we_o=1, mem_to_reg_o=1, reg_dst_o=0 -> IF.
// - WB_ALU: reg_we_o=1, mem_to_reg_o=0 -> IF.
// - EX_BR: alu_src_a_o=1, alu_src_b_o=0, alu_op_o = BEQ or BNE, pc_src_o=1.
//   - pc_we_o = zero_i for beq, ~zero_i for bne. Next state IF.
// - EX_J: pc_we_o=1, pc_src_o=2 -> IF.
// - Instruction latency in cycles, excluding memory wait states:
//   - lw 5; R/addi/lui/sw 4; beq/bne/j 3.
// - Memory wait counter:
//   - Counts consecutive cycles with mem_req_o=1 and mem_ready_i=0; cleared on ready or
//     on state change.
//   - When it reaches MEM_TIMEOUT (MEM_TIMEOUT > 0): bus_err_o=1, request dropped,
//     next state IF, no register/PC/IR write.
//   - If mem_ready_i and the timeout coincide, ready wins.
// - State register width 4; unused encodings recover to IF on the next edge with all
//   outputs 0.
// STRUCTURE
// - Shared package / header: opcode constants; state encodings; ALUOp constants
//   ADD=3'b000, BEQ=3'b001, RTYPE=3'b010, BNE=3'b110, LUI=3'b101; alu_src_b/pc_src codes.
// - Single module, no sub-module: one state register and one combinational next-state
//   and output block.
// - Wait counter width $clog2(MEM_TIMEOUT+1), minimum 1.
// TESTING
// - R-type add, mem_ready_i=1 in IF:
//   - states IF,ID,EX_R,WB_ALU; alu_op_o=010 in EX_R; reg_we_o=1 only in cycle 4.
// - lw with mem_ready_i delayed 3 cycles in MEM:
//   - MEM held 4 cycles, mem_we_o=0; WB_MEM asserts reg_we_o & mem_to_reg_o.
// - beq with zero_i=1, then zero_i=0:
//   - pc_we_o=1 with pc_src_o=1, then pc_we_o=0; both return to IF after 3 cycles.
// - Opcode 111111:
//   - ill_op_o pulses once in ID, next state IF; no reg/mem write is ever asserted.
// - MEM_TIMEOUT=4, mem_ready_i held 0 in IF:
//   - bus_err_o in the 4th wait cycle; ir_we_o never asserted; FSM restarts in IF.
// - rst_i asserted while in MEM (sw):
//   - next cycle IF, mem_req_o=0, mem_we_o=0, all outputs 0.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS main control FSM.
// Opcodes, state encodings, ALUOp codes and datapath mux selects.
package multi_cycle_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_BEQ   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_BNE   = 3'b110;
  localparam logic [2:0] ALU_LUI   = 3'b101;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_4    = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU  = 2'd0;
  localparam logic [1:0] PCSRC_OUT  = 2'd1;
  localparam logic [1:0] PCSRC_JUMP = 2'd2;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_MEM     = 4'd5,
    S_WB_MEM  = 4'd6,
    S_WB_ALU  = 4'd7,
    S_EX_BR   = 4'd8,
    S_EX_J    = 4'd9
  } state_t;

endpackage

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Sequences IF/ID/EX/MEM/WB over a shared handshaked memory.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic [2:0] alu_op_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       ir_we_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       reg_we_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       ill_op_o,
  output logic       bus_err_o,
  output logic [3:0] state_o
);

  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t        state;
  state_t        state_nx;
  logic [5:0]    op;
  logic [CW-1:0] cnt;
  logic          to_hit;

  assign state_o = state;

  // Timeout fires in the wait cycle that would be the MEM_TIMEOUT-th one.
  assign to_hit = (MEM_TIMEOUT > 0) && !mem_ready_i
                  && (cnt == TO_LAST);

  // Next-state and Moore/qualified outputs from state and latched opcode.
  always_comb begin
    state_nx     = S_IF;
    alu_op_o     = ALU_ADD;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_RT;
    pc_we_o      = 1'b0;
    pc_src_o     = PCSRC_ALU;
    ir_we_o      = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    reg_we_o     = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    ill_op_o     = 1'b0;
    bus_err_o    = 1'b0;
    case (state)
      S_IF: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRCB_4;
        if (mem_ready_i) begin
          ir_we_o  = 1'b1;
          pc_we_o  = 1'b1;
          state_nx = S_ID;
        end else if (to_hit) begin
          bus_err_o = 1'b1;
          state_nx  = S_IF;
        end else begin
          state_nx = S_IF;
        end
      end
      S_ID: begin
        alu_src_b_o = SRCB_IMM2;
        unique case (1'b1)
          (opcode_i == OP_R):    state_nx = S_EX_R;
          (opcode_i == OP_ADDI),
          (opcode_i == OP_LUI):  state_nx = S_EX_I;
          (opcode_i == OP_LW),
          (opcode_i == OP_SW):   state_nx = S_EX_ADDR;
          (opcode_i == OP_BEQ),
          (opcode_i == OP_BNE):  state_nx = S_EX_BR;
          (opcode_i == OP_J):    state_nx = S_EX_J;
          default: begin
            ill_op_o = 1'b1;
            state_nx = S_IF;
          end
        endcase
      end
      S_EX_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_RTYPE;
        state_nx    = S_WB_ALU;
      end
      S_EX_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = (op == OP_LUI) ? ALU_LUI : ALU_ADD;
        state_nx    = S_WB_ALU;
      end
      S_EX_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        state_nx    = S_MEM;
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        mem_we_o  = (op == OP_SW);
        if (mem_ready_i) begin
          state_nx = (op == OP_SW) ? S_IF : S_WB_MEM;
        end else if (to_hit) begin
          bus_err_o = 1'b1;
          state_nx  = S_IF;
        end else begin
          state_nx = S_MEM;
        end
      end
      S_WB_MEM: begin
        reg_we_o     = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_WB_ALU: begin
        reg_we_o  = 1'b1;
        reg_dst_o = (op == OP_R);
      end
      S_EX_BR: begin
        alu_src_a_o = 1'b1;
        pc_src_o    = PCSRC_OUT;
        if (op == OP_BNE) begin
          alu_op_o = ALU_BNE;
          pc_we_o  = ~zero_i;
        end else begin
          alu_op_o = ALU_BEQ;
          pc_we_o  = zero_i;
        end
      end
      S_EX_J: begin
        pc_we_o  = 1'b1;
        pc_src_o = PCSRC_JUMP;
      end
      default: state_nx = S_IF;
    endcase
    if (rst_i) begin
      alu_op_o     = ALU_ADD;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = SRCB_RT;
      pc_we_o      = 1'b0;
      pc_src_o     = PCSRC_ALU;
      ir_we_o      = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      iord_o       = 1'b0;
      reg_we_o     = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      ill_op_o     = 1'b0;
      bus_err_o    = 1'b0;
    end
  end

  // State, latched opcode and memory wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IF;
      op    <= 6'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_ID) op <= opcode_i;
      if (mem_req_o && !mem_ready_i && !bus_err_o
          && (state_nx == state))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl with MEM_TIMEOUT=4.
// Stimulus pushes per-cycle expectations; a negedge monitor checks them.
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic       pcwe;
    logic [1:0] pcsrc;
    logic       ir;
    logic       req;
    logic       we;
    logic       iord;
    logic       rwe;
    logic       rdst;
    logic       m2r;
    logic       ill;
    logic       be;
  } exp_t;

  typedef struct {
    exp_t  e;
    string nm;
  } item_t;

  //                         st    alu   sa  sb  pw  ps  ir rq we io rw rd mr il be
  localparam exp_t E_RST  = '{4'd0,3'd0,1'b0,2'd0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_FET  = '{4'd0,3'd0,1'b0,2'd1,1'b1,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_IFW  = '{4'd0,3'd0,1'b0,2'd1,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_IFTO = '{4'd0,3'd0,1'b0,2'd1,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
  localparam exp_t E_ID   = '{4'd1,3'd0,1'b0,2'd3,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_ILL  = '{4'd1,3'd0,1'b0,2'd3,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam exp_t E_EXR  = '{4'd2,3'd2,1'b1,2'd0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_ADDI = '{4'd3,3'd0,1'b1,2'd2,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_LUI  = '{4'd3,3'd5,1'b1,2'd2,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_EXA  = '{4'd4,3'd0,1'b1,2'd2,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_MLW  = '{4'd5,3'd0,1'b0,2'd0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_MSW  = '{4'd5,3'd0,1'b0,2'd0,1'b0,2'd0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_MRST = '{4'd5,3'd0,1'b0,2'd0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_WBM  = '{4'd6,3'd0,1'b0,2'd0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
  localparam exp_t E_WBR  = '{4'd7,3'd0,1'b0,2'd0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
  localparam exp_t E_WBI  = '{4'd7,3'd0,1'b0,2'd0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_BQT  = '{4'd8,3'd1,1'b1,2'd0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_BQN  = '{4'd8,3'd1,1'b1,2'd0,1'b0,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_BNT  = '{4'd8,3'd6,1'b1,2'd0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam exp_t E_J    = '{4'd9,3'd0,1'b0,2'd0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opc = 6'd0;
  logic       zero = 1'b0;
  logic       rdy = 1'b0;

  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       ill_op;
  logic       bus_err;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  item_t q[$];

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .opcode_i     (opc),
    .zero_i       (zero),
    .mem_ready_i  (rdy),
    .alu_op_o     (alu_op),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .pc_we_o      (pc_we),
    .pc_src_o     (pc_src),
    .ir_we_o      (ir_we),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .iord_o       (iord),
    .reg_we_o     (reg_we),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .ill_op_o     (ill_op),
    .bus_err_o    (bus_err),
    .state_o      (state)
  );

  task automatic cyc(input logic r, input logic [5:0] o,
                     input logic z, input logic m,
                     input string nm, input exp_t e);
    item_t it;
    @(posedge clk);
    #1;
    rst  = r;
    opc  = o;
    zero = z;
    rdy  = m;
    it.e  = e;
    it.nm = nm;
    q.push_back(it);
  endtask

  // Monitor: outputs settle after the #1 drive; compare at negedge.
  initial begin
    exp_t  act;
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it  = q.pop_front();
        act = '{state, alu_op, alu_src_a, alu_src_b, pc_we, pc_src,
                ir_we, mem_req, mem_we, iord, reg_we, reg_dst,
                mem_to_reg, ill_op, bus_err};
        total++;
        if (act !== it.e) begin
          bad++;
          $display("FAIL %s: got %h want %h", it.nm, act, it.e);
        end
      end
    end
  end

  initial begin
    cyc(1, 6'h00, 0, 0, "reset0", E_RST);
    cyc(1, 6'h00, 0, 1, "reset1", E_RST);
    // R-type add
    cyc(0, 6'b000000, 0, 1, "r_if", E_FET);
    cyc(0, 6'b000000, 0, 0, "r_id", E_ID);
    cyc(0, 6'b000000, 0, 0, "r_ex", E_EXR);
    cyc(0, 6'b000000, 0, 0, "r_wb", E_WBR);
    // lw, ready delayed 3 cycles in MEM
    cyc(0, 6'b100011, 0, 1, "lw_if", E_FET);
    cyc(0, 6'b100011, 0, 0, "lw_id", E_ID);
    cyc(0, 6'b100011, 0, 0, "lw_ex", E_EXA);
    cyc(0, 6'b100011, 0, 0, "lw_mem0", E_MLW);
    cyc(0, 6'b100011, 0, 0, "lw_mem1", E_MLW);
    cyc(0, 6'b100011, 0, 0, "lw_mem2", E_MLW);
    cyc(0, 6'b100011, 0, 1, "lw_mem3", E_MLW);
    cyc(0, 6'b100011, 0, 0, "lw_wb", E_WBM);
    // beq taken, beq not taken, bne taken
    cyc(0, 6'b000100, 0, 1, "beq1_if", E_FET);
    cyc(0, 6'b000100, 0, 0, "beq1_id", E_ID);
    cyc(0, 6'b000100, 1, 0, "beq1_ex", E_BQT);
    cyc(0, 6'b000100, 0, 1, "beq0_if", E_FET);
    cyc(0, 6'b000100, 0, 0, "beq0_id", E_ID);
    cyc(0, 6'b000100, 0, 0, "beq0_ex", E_BQN);
    cyc(0, 6'b000101, 0, 1, "bne_if", E_FET);
    cyc(0, 6'b000101, 0, 0, "bne_id", E_ID);
    cyc(0, 6'b000101, 0, 0, "bne_ex", E_BNT);
    // illegal opcode, then IF timeout with ready held low
    cyc(0, 6'b111111, 0, 1, "ill_if", E_FET);
    cyc(0, 6'b111111, 0, 0, "ill_id", E_ILL);
    cyc(0, 6'b000000, 0, 0, "to_w1", E_IFW);
    cyc(0, 6'b000000, 0, 0, "to_w2", E_IFW);
    cyc(0, 6'b000000, 0, 0, "to_w3", E_IFW);
    cyc(0, 6'b000000, 0, 0, "to_w4", E_IFTO);
    cyc(0, 6'b000000, 0, 0, "to_rst", E_IFW);
    // addi and lui
    cyc(0, 6'b001000, 0, 1, "addi_if", E_FET);
    cyc(0, 6'b001000, 0, 0, "addi_id", E_ID);
    cyc(0, 6'b001000, 0, 0, "addi_ex", E_ADDI);
    cyc(0, 6'b001000, 0, 0, "addi_wb", E_WBI);
    cyc(0, 6'b001111, 0, 1, "lui_if", E_FET);
    cyc(0, 6'b001111, 0, 0, "lui_id", E_ID);
    cyc(0, 6'b001111, 0, 0, "lui_ex", E_LUI);
    cyc(0, 6'b001111, 0, 0, "lui_wb", E_WBI);
    // jump
    cyc(0, 6'b000010, 0, 1, "j_if", E_FET);
    cyc(0, 6'b000010, 0, 0, "j_id", E_ID);
    cyc(0, 6'b000010, 0, 0, "j_ex", E_J);
    // sw completing, then sw aborted by reset in MEM
    cyc(0, 6'b101011, 0, 1, "sw_if", E_FET);
    cyc(0, 6'b101011, 0, 0, "sw_id", E_ID);
    cyc(0, 6'b101011, 0, 0, "sw_ex", E_EXA);
    cyc(0, 6'b101011, 0, 1, "sw_mem", E_MSW);
    cyc(0, 6'b101011, 0, 1, "sw2_if", E_FET);
    cyc(0, 6'b101011, 0, 0, "sw2_id", E_ID);
    cyc(0, 6'b101011, 0, 0, "sw2_ex", E_EXA);
    cyc(0, 6'b101011, 0, 0, "sw2_mem", E_MSW);
    cyc(1, 6'b101011, 0, 1, "sw2_rstmem", E_MRST);
    cyc(1, 6'b101011, 0, 0, "sw2_rstif", E_RST);
    cyc(0, 6'b000000, 0, 0, "post_rst", E_IFW);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
